// File: rtl/pci_blue_pkg.sv
// Shared pci_blue constants: reset-sequencer state encodings and parameter defaults.
package pci_blue_pkg;

    typedef enum logic [2:0] {
        ST_HOLD       = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_STRETCH    = 3'd2,
        ST_STAGGER    = 3'd3,
        ST_RUN        = 3'd4,
        ST_HOST_DRIVE = 3'd5
    } seq_state_t;

    localparam int DEF_NUM_DOMAINS       = 4;
    localparam int DEF_STRETCH_CYCLES    = 16;
    localparam int DEF_STAGGER_CYCLES    = 2;
    localparam int DEF_LOCK_TIMEOUT      = 1024;
    localparam int DEF_HOST_RESET_CYCLES = 32;

    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/pci_reset_pulse_stretcher.sv
// Per-domain soft-reset stretcher: keeps one domain in reset for STRETCH_CYCLES
// after the most recent request accepted while the sequencer is running.
module pci_reset_pulse_stretcher
    import pci_blue_pkg::*;
#(
    parameter int STRETCH_CYCLES = DEF_STRETCH_CYCLES
) (
    input  logic pci_clk,
    input  logic pci_reset_l,
    input  logic run,
    input  logic req,
    output logic active_next
);
    localparam int CW = $clog2(STRETCH_CYCLES + 1);
    localparam logic [CW-1:0] LOAD = CW'(STRETCH_CYCLES);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] remaining;
    logic [CW-1:0] remaining_next;

    // active_next lets the sequencer register the domain output on the same edge as the load
    always_comb begin
        remaining_next = remaining;
        if (!run) begin
            remaining_next = '0;
        end else if (req) begin
            remaining_next = LOAD;
        end else if (remaining != '0) begin
            remaining_next = remaining - ONE;
        end
        active_next = (remaining_next != '0);
    end

    always_ff @(posedge pci_clk) begin
        if (!pci_reset_l) begin
            remaining <= '0;
        end else begin
            remaining <= remaining_next;
        end
    end

endmodule

// File: rtl/pci_reset_sequencer.sv
// PCI reset sequencer: synchronises the pad reset, waits for PLL lock, stretches,
// then releases internal reset domains one by one; can also drive PCI reset as host.
module pci_reset_sequencer
    import pci_blue_pkg::*;
#(
    parameter int NUM_DOMAINS       = DEF_NUM_DOMAINS,
    parameter int STRETCH_CYCLES    = DEF_STRETCH_CYCLES,
    parameter int STAGGER_CYCLES    = DEF_STAGGER_CYCLES,
    parameter int LOCK_TIMEOUT      = DEF_LOCK_TIMEOUT,
    parameter int HOST_RESET_CYCLES = DEF_HOST_RESET_CYCLES
) (
    input  logic                   pci_clk,
    input  logic                   pci_reset_l,
    input  logic                   pci_reset_raw,
    input  logic                   pci_pll_locked,
    input  logic                   pci_pll_bypass,
    input  logic                   host_reset_req,
    input  logic [NUM_DOMAINS-1:0] sw_reset_req,
    output logic [NUM_DOMAINS-1:0] domain_reset_l,
    output logic                   pci_reset_out_oe_comb,
    output logic [2:0]             seq_state,
    output logic                   lock_timeout_err
);
    localparam int CNT_MAX = max_of4(STRETCH_CYCLES, STAGGER_CYCLES, LOCK_TIMEOUT, HOST_RESET_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] HOST_LAST    = CNT_W'(HOST_RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_DOMAINS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE      = IDX_W'(1);

    logic                   raw_meta;
    logic                   raw_sync;
    seq_state_t             state;
    seq_state_t             state_next;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_next;
    logic [IDX_W-1:0]       idx;
    logic [IDX_W-1:0]       idx_next;
    logic                   err_set;
    logic                   lock_ok;
    logic                   go_hold;
    logic                   in_run;
    logic [NUM_DOMAINS-1:0] soft_active;
    logic [NUM_DOMAINS-1:0] domain_next;

    // Once the lock wait has timed out we run unlocked, so lock loss no longer aborts
    assign lock_ok   = pci_pll_locked | pci_pll_bypass | lock_timeout_err;
    assign go_hold   = raw_sync | ~lock_ok;
    assign in_run    = (state == ST_RUN);
    assign seq_state = state;

    for (genvar i = 0; i < NUM_DOMAINS; i++) begin : g_stretch
        pci_reset_pulse_stretcher #(
            .STRETCH_CYCLES(STRETCH_CYCLES)
        ) u_stretch (
            .pci_clk    (pci_clk),
            .pci_reset_l(pci_reset_l),
            .run        (in_run),
            .req        (sw_reset_req[i]),
            .active_next(soft_active[i])
        );
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx;
        err_set    = 1'b0;
        case (state)
            ST_HOLD: begin
                if (!raw_sync) begin
                    state_next = ST_WAIT_LOCK;
                    cnt_next   = '0;
                end
            end
            ST_WAIT_LOCK: begin
                if (raw_sync) begin
                    state_next = ST_HOLD;
                end else if (pci_pll_locked || pci_pll_bypass) begin
                    state_next = ST_STRETCH;
                    cnt_next   = '0;
                end else if (cnt == LOCK_LAST) begin
                    err_set    = 1'b1;
                    state_next = ST_STRETCH;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            ST_STRETCH: begin
                if (go_hold) begin
                    state_next = ST_HOLD;
                end else if (cnt == STRETCH_LAST) begin
                    state_next = ST_STAGGER;
                    cnt_next   = '0;
                    idx_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            ST_STAGGER: begin
                if (go_hold) begin
                    state_next = ST_HOLD;
                end else if (idx == IDX_LAST) begin
                    state_next = ST_RUN;
                end else if (cnt == STAGGER_LAST) begin
                    idx_next = idx + IDX_ONE;
                    cnt_next = '0;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            ST_RUN: begin
                if (go_hold) begin
                    state_next = ST_HOLD;
                end else if (host_reset_req) begin
                    state_next = ST_HOST_DRIVE;
                    cnt_next   = '0;
                end
            end
            ST_HOST_DRIVE: begin
                if (cnt == HOST_LAST) begin
                    state_next = ST_HOLD;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            default: begin
                state_next = ST_HOLD;
            end
        endcase
    end

    // Domain levels follow the next state so every release and abort is registered on the same edge
    always_comb begin
        domain_next = '0;
        case (state_next)
            ST_STAGGER: begin
                for (int i = 0; i < NUM_DOMAINS; i++) begin
                    domain_next[i] = (IDX_W'(i) <= idx_next);
                end
            end
            ST_RUN: begin
                domain_next = ~soft_active;
            end
            default: begin
                domain_next = '0;
            end
        endcase
    end

    always_ff @(posedge pci_clk) begin
        if (!pci_reset_l) begin
            raw_meta              <= 1'b0;
            raw_sync              <= 1'b0;
            state                 <= ST_HOLD;
            cnt                   <= '0;
            idx                   <= '0;
            domain_reset_l        <= '0;
            pci_reset_out_oe_comb <= 1'b0;
            lock_timeout_err      <= 1'b0;
        end else begin
            raw_meta              <= pci_reset_raw;
            raw_sync              <= raw_meta;
            state                 <= state_next;
            cnt                   <= cnt_next;
            idx                   <= idx_next;
            domain_reset_l        <= domain_next;
            pci_reset_out_oe_comb <= (state_next == ST_HOST_DRIVE);
            lock_timeout_err      <= lock_timeout_err | err_set;
        end
    end

endmodule

// File: tb/tb_pci_reset_sequencer.sv
// Self-checking bench for pci_reset_sequencer: expected waveforms are derived from
// stimulus event times (raw fall, lock arrival, requests) using the timing rules.
module tb_pci_reset_sequencer;

    localparam int N       = 4;
    localparam int STRETCH = 16;
    localparam int STAGGER = 2;
    localparam int LOCK_TO = 64;
    localparam int HOST    = 32;
    localparam int SYNC    = 3;

    logic         pci_clk;
    logic         pci_reset_l;
    logic         pci_reset_raw;
    logic         pci_pll_locked;
    logic         pci_pll_bypass;
    logic         host_reset_req;
    logic [N-1:0] sw_reset_req;
    logic [N-1:0] domain_reset_l;
    logic         pci_reset_out_oe_comb;
    logic [2:0]   seq_state;
    logic         lock_timeout_err;

    int checks = 0;
    int errors = 0;
    int now    = 0;

    pci_reset_sequencer #(
        .NUM_DOMAINS      (N),
        .STRETCH_CYCLES   (STRETCH),
        .STAGGER_CYCLES   (STAGGER),
        .LOCK_TIMEOUT     (LOCK_TO),
        .HOST_RESET_CYCLES(HOST)
    ) dut (
        .pci_clk              (pci_clk),
        .pci_reset_l          (pci_reset_l),
        .pci_reset_raw        (pci_reset_raw),
        .pci_pll_locked       (pci_pll_locked),
        .pci_pll_bypass       (pci_pll_bypass),
        .host_reset_req       (host_reset_req),
        .sw_reset_req         (sw_reset_req),
        .domain_reset_l       (domain_reset_l),
        .pci_reset_out_oe_comb(pci_reset_out_oe_comb),
        .seq_state            (seq_state),
        .lock_timeout_err     (lock_timeout_err)
    );

    initial pci_clk = 1'b0;
    always #5 pci_clk = ~pci_clk;

    task automatic tick();
        @(posedge pci_clk);
        #1;
        now++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, now, obs, exp);
        end
    endtask

    // Expected state after edge t, given raw falling after edge e_f and leaving lock wait at t_leave
    function automatic int exp_state(input int t, input int e_f, input int t_leave);
        if (t < e_f + SYNC) return 0;
        if (t < t_leave) return 1;
        if (t < t_leave + STRETCH) return 2;
        if (t < t_leave + STRETCH + STAGGER * (N - 1) + 1) return 3;
        return 4;
    endfunction

    function automatic logic [N-1:0] exp_dom(input int t, input int t_leave);
        logic [N-1:0] r;
        for (int k = 0; k < N; k++) r[k] = (t >= t_leave + STRETCH + STAGGER * k);
        return r;
    endfunction

    // Walks a full release from HOLD, injecting ignored host/sw requests outside RUN
    task automatic run_release(input int e_f, input int lock_at, input bit use_bypass,
                               input logic err_prior, input int stop_off, output int t_leave);
        int   lock_edge;
        int   st;
        logic timed_out;
        lock_edge = lock_at + 1;
        if (lock_at < 0 || lock_edge > e_f + SYNC + LOCK_TO) begin
            t_leave   = e_f + SYNC + LOCK_TO;
            timed_out = 1'b1;
        end else begin
            t_leave   = (lock_edge > e_f + SYNC + 1) ? lock_edge : e_f + SYNC + 1;
            timed_out = 1'b0;
        end
        while (now < t_leave + stop_off) begin
            st = exp_state(now, e_f, t_leave);
            check("seq_state", 32'(seq_state), 32'(st));
            check("domain_reset_l", 32'(domain_reset_l), 32'(exp_dom(now, t_leave)));
            check("oe", 32'(pci_reset_out_oe_comb), 32'd0);
            check("lock_timeout_err", 32'(lock_timeout_err),
                  32'(err_prior | (timed_out && now >= t_leave)));
            if (now == lock_at) begin
                if (use_bypass) pci_pll_bypass = 1'b1;
                else pci_pll_locked = 1'b1;
            end
            if (st != 4) begin
                sw_reset_req   = N'($urandom);
                host_reset_req = 1'($urandom_range(0, 1));
            end else begin
                sw_reset_req   = '0;
                host_reset_req = 1'b0;
            end
            tick();
        end
        sw_reset_req   = '0;
        host_reset_req = 1'b0;
    endtask

    initial begin
        int           e_f;
        int           e_h;
        int           e_r;
        int           t_leave;
        int           base;
        int           low_cnt;
        int           oe_cnt;
        bit           use_byp;
        logic [N-1:0] req;
        logic [N-1:0] expd;
        int           lo_from [N];
        int           lo_until[N];

        pci_reset_l    = 1'b0;
        pci_reset_raw  = 1'b1;
        pci_pll_locked = 1'b0;
        pci_pll_bypass = 1'b0;
        host_reset_req = 1'b0;
        sw_reset_req   = '0;
        repeat (3) tick();
        check("reset_state", 32'(seq_state), 32'd0);
        check("reset_domains", 32'(domain_reset_l), 32'd0);
        check("reset_oe", 32'(pci_reset_out_oe_comb), 32'd0);
        check("reset_err", 32'(lock_timeout_err), 32'd0);

        // Power-on release with a random lock source and lock delay
        pci_reset_l = 1'b1;
        repeat ($urandom_range(6, 12)) tick();
        use_byp       = 1'($urandom_range(0, 1));
        pci_reset_raw = 1'b0;
        e_f           = now;
        run_release(e_f, e_f + $urandom_range(0, 12), use_byp, 1'b0, 26, t_leave);

        // Soft resets in RUN: directed restart on domain 2, then random requests
        base    = now;
        low_cnt = 0;
        for (int i = 0; i < N; i++) begin
            lo_from[i]  = 0;
            lo_until[i] = 0;
        end
        for (int c = 0; c < 70; c++) begin
            expd = '1;
            for (int i = 0; i < N; i++)
                if (now >= lo_from[i] && now < lo_until[i]) expd[i] = 1'b0;
            check("sw_domains", 32'(domain_reset_l), 32'(expd));
            check("sw_state", 32'(seq_state), 32'd4);
            if (c < 30 && domain_reset_l[2] === 1'b0) low_cnt++;
            if (c == 0 || c == 5) req = N'(4'b0100);
            else if (c >= 30 && c < 50 && $urandom_range(0, 4) == 0) req = N'($urandom);
            else req = '0;
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    if (now + 1 >= lo_until[i]) lo_from[i] = now + 1;
                    lo_until[i] = now + 1 + STRETCH;
                end
            end
            sw_reset_req = req;
            tick();
        end
        sw_reset_req = '0;
        check("sw_dom2_low_cycles", 32'(low_cnt), 32'd21);

        // Lock loss together with host and soft requests: lock loss wins
        pci_pll_locked = 1'b0;
        pci_pll_bypass = 1'b0;
        host_reset_req = 1'b1;
        sw_reset_req   = N'($urandom);
        tick();
        host_reset_req = 1'b0;
        sw_reset_req   = '0;
        check("lockloss_state", 32'(seq_state), 32'd0);
        check("lockloss_domains", 32'(domain_reset_l), 32'd0);
        check("lockloss_oe", 32'(pci_reset_out_oe_comb), 32'd0);
        run_release(now - 2, now, 1'b0, 1'b0, 26, t_leave);

        // Host-driven reset with pad loopback on the raw input
        e_h            = now;
        host_reset_req = 1'b1;
        tick();
        host_reset_req = 1'b0;
        pci_reset_raw  = 1'b1;
        oe_cnt         = 0;
        while (now < e_h + 1 + HOST) begin
            check("host_state", 32'(seq_state), 32'd5);
            check("host_oe", 32'(pci_reset_out_oe_comb), 32'd1);
            check("host_domains", 32'(domain_reset_l), 32'd0);
            if (pci_reset_out_oe_comb === 1'b1) oe_cnt++;
            host_reset_req = 1'($urandom_range(0, 1));
            sw_reset_req   = N'($urandom);
            tick();
        end
        host_reset_req = 1'b0;
        sw_reset_req   = '0;
        check("host_oe_cycles", 32'(oe_cnt), 32'(HOST));
        check("host_end_oe", 32'(pci_reset_out_oe_comb), 32'd0);
        check("host_end_state", 32'(seq_state), 32'd0);
        pci_reset_raw = 1'b0;
        run_release(now, now, 1'b0, 1'b0, 26, t_leave);

        // Raw reset from RUN: all domains low exactly three edges later
        pci_reset_raw = 1'b1;
        e_r           = now;
        for (int k = 0; k < 8; k++) begin
            check("raw_run_state", 32'(seq_state), (now < e_r + SYNC) ? 32'd4 : 32'd0);
            check("raw_run_domains", 32'(domain_reset_l), (now < e_r + SYNC) ? 32'hF : 32'd0);
            tick();
        end

        // Raw reset arriving mid-stagger after domain 1 has been released
        pci_reset_raw = 1'b0;
        e_f           = now;
        run_release(e_f, now, 1'b0, 1'b0, STRETCH + STAGGER + $urandom_range(0, 3), t_leave);
        pci_reset_raw = 1'b1;
        e_r           = now;
        for (int k = 0; k < 8; k++) begin
            check("raw_stagger_state", 32'(seq_state),
                  (now < e_r + SYNC) ? 32'(exp_state(now, e_f, t_leave)) : 32'd0);
            check("raw_stagger_domains", 32'(domain_reset_l),
                  (now < e_r + SYNC) ? 32'(exp_dom(now, t_leave)) : 32'd0);
            tick();
        end

        // No lock at all: timeout flags the error and the sequence still completes
        pci_pll_locked = 1'b0;
        pci_pll_bypass = 1'b0;
        pci_reset_raw  = 1'b0;
        e_f            = now;
        run_release(e_f, -1, 1'b0, 1'b0, 26, t_leave);
        check("timeout_err_sticky", 32'(lock_timeout_err), 32'd1);

        // Only the block reset clears the error; then a bypass start with no wait
        pci_reset_l = 1'b0;
        tick();
        check("rst2_err", 32'(lock_timeout_err), 32'd0);
        check("rst2_state", 32'(seq_state), 32'd0);
        check("rst2_domains", 32'(domain_reset_l), 32'd0);
        tick();
        pci_reset_l   = 1'b1;
        pci_reset_raw = 1'b1;
        repeat (8) tick();
        pci_pll_bypass = 1'b1;
        pci_reset_raw  = 1'b0;
        e_f            = now;
        run_release(e_f, now, 1'b1, 1'b0, 26, t_leave);

        // Block reset in the middle of a host drive drops the pad enable on the next edge
        host_reset_req = 1'b1;
        tick();
        host_reset_req = 1'b0;
        repeat ($urandom_range(2, 20)) tick();
        check("hd_oe", 32'(pci_reset_out_oe_comb), 32'd1);
        check("hd_state", 32'(seq_state), 32'd5);
        pci_reset_l = 1'b0;
        tick();
        check("rstd_oe", 32'(pci_reset_out_oe_comb), 32'd0);
        check("rstd_state", 32'(seq_state), 32'd0);
        check("rstd_domains", 32'(domain_reset_l), 32'd0);
        pci_reset_l = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
